// File: rtl/mat_stream_pkg.sv
// -----------------------------------------------------------------------------
// mat_stream_pkg
// Shared definitions for the matrix stream driver: run-state encoding,
// result-stream length and default widths.
// -----------------------------------------------------------------------------
package mat_stream_pkg;

    localparam int DEF_DATA_W = 32;  // beat width for A, B and C streams
    localparam int DEF_K_MAX  = 64;  // largest supported inner dimension
    localparam int C_BEATS    = 4;   // 2x2 result, one beat per element

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SEND_A,
        ST_SEND_B,
        ST_RECV_C,
        ST_FINISH
    } state_t;

endpackage

// File: rtl/mat_stream_driver_axis_buf_tx.sv
// -----------------------------------------------------------------------------
// axis_buf_tx
// Operand beat buffer with an AXI-Stream master read side. The buffer is
// filled through a simple write port; while `en` is high the stored beats
// are presented in address order, advancing only on handshake, with tlast
// on beat len-1.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   wr_en/addr/data   buffer write port (caller gates it while a run is busy)
//   en                stream enable; also the tvalid level
//   len               number of beats to send (1..DEPTH)
//   tdata/tvalid/
//   tready/tlast      AXI-Stream master
//   last_hs           one-cycle pulse on the handshake of the final beat
// -----------------------------------------------------------------------------
module axis_buf_tx #(
    parameter  int DATA_W = 32,
    parameter  int DEPTH  = 128,
    localparam int ADDR_W = $clog2(DEPTH),
    localparam int CNT_W  = ADDR_W + 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              en,
    input  logic [CNT_W-1:0]  len,
    output logic [DATA_W-1:0] tdata,
    output logic              tvalid,
    input  logic              tready,
    output logic              tlast,
    output logic              last_hs
);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [CNT_W-1:0]  cnt;
    logic              hs;

    // NOTE: the operand store has no reset; it is pure data, always written
    // before use, and leaving it reset-free lets it map onto plain RAM/flops.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Valid is the enable alone, never a function of ready. The counter is
    // one bit wider than the address so len-1 = DEPTH-1 never wraps.
    assign tvalid  = en;
    assign hs      = tvalid && tready;
    assign tdata   = mem[cnt[ADDR_W-1:0]];
    assign tlast   = en && (cnt == len - CNT_W'(1));
    assign last_hs = hs && tlast;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (!en) begin
            cnt <= '0;
        end else if (hs) begin
            cnt <= tlast ? '0 : cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/mat_stream_driver.sv
// -----------------------------------------------------------------------------
// mat_stream_driver
// Host-side driver for the 2x2 matrix compute core. A (2xK) and B (Kx2)
// operands are written into local buffers in stream beat order. A `go`
// with a legal K raises core_start, streams A then B as AXI-Stream master,
// then collects the four C beats as AXI-Stream slave into a readable
// result buffer. done/error are sticky until the next go.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   buf_wr_*              operand write port (sel 0=A, 1=B); dropped while busy
//   cfg_k                 inner dimension, sampled on go
//   go                    single-cycle run request (ignored unless idle)
//   busy, done, error     run status (done/error sticky)
//   core_start            start level to the compute core
//   m_axis_a_*, m_axis_b_* operand streams (master)
//   s_axis_c_*            result stream (slave)
//   c_rd_addr, c_rd_data  combinational result read, index = row*2+col
// -----------------------------------------------------------------------------
module mat_stream_driver
    import mat_stream_pkg::*;
#(
    parameter  int DATA_W = DEF_DATA_W,
    parameter  int K_MAX  = DEF_K_MAX,
    localparam int AW     = $clog2(2 * K_MAX)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              buf_wr_en,
    input  logic              buf_wr_sel,
    input  logic [AW-1:0]     buf_wr_addr,
    input  logic [DATA_W-1:0] buf_wr_data,
    input  logic [15:0]       cfg_k,
    input  logic              go,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic              core_start,
    output logic [DATA_W-1:0] m_axis_a_tdata,
    output logic              m_axis_a_tvalid,
    input  logic              m_axis_a_tready,
    output logic              m_axis_a_tlast,
    output logic [DATA_W-1:0] m_axis_b_tdata,
    output logic              m_axis_b_tvalid,
    input  logic              m_axis_b_tready,
    output logic              m_axis_b_tlast,
    input  logic [DATA_W-1:0] s_axis_c_tdata,
    input  logic              s_axis_c_tvalid,
    output logic              s_axis_c_tready,
    input  logic              s_axis_c_tlast,
    input  logic [1:0]        c_rd_addr,
    output logic [DATA_W-1:0] c_rd_data
);

    localparam int         CNT_W  = AW + 1;
    localparam logic [1:0] C_LAST = 2'(C_BEATS - 1);

    state_t            state;
    logic [AW-1:0]     k_r;
    logic [CNT_W-1:0]  len;
    logic [1:0]        c_cnt;
    logic [DATA_W-1:0] c_buf [C_BEATS];
    logic              cfg_ok;
    logic              a_last_hs;
    logic              b_last_hs;
    logic              c_hs;

    // Each operand is 2*K beats long.
    assign len    = {k_r, 1'b0};
    assign cfg_ok = (cfg_k != 16'd0) && (cfg_k <= 16'(K_MAX));

    assign s_axis_c_tready = (state == ST_RECV_C);
    assign c_hs            = s_axis_c_tvalid && s_axis_c_tready;
    assign c_rd_data       = c_buf[c_rd_addr];

    axis_buf_tx #(.DATA_W(DATA_W), .DEPTH(2 * K_MAX)) u_tx_a (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (buf_wr_en && !busy && !buf_wr_sel),
        .wr_addr (buf_wr_addr),
        .wr_data (buf_wr_data),
        .en      (state == ST_SEND_A),
        .len     (len),
        .tdata   (m_axis_a_tdata),
        .tvalid  (m_axis_a_tvalid),
        .tready  (m_axis_a_tready),
        .tlast   (m_axis_a_tlast),
        .last_hs (a_last_hs)
    );

    axis_buf_tx #(.DATA_W(DATA_W), .DEPTH(2 * K_MAX)) u_tx_b (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (buf_wr_en && !busy && buf_wr_sel),
        .wr_addr (buf_wr_addr),
        .wr_data (buf_wr_data),
        .en      (state == ST_SEND_B),
        .len     (len),
        .tdata   (m_axis_b_tdata),
        .tvalid  (m_axis_b_tvalid),
        .tready  (m_axis_b_tready),
        .tlast   (m_axis_b_tlast),
        .last_hs (b_last_hs)
    );

    // Run sequencer. busy and core_start are registered alongside the state
    // so they change on the same edge as the state they describe.
    // NOTE: every assignment here is non-blocking, so all registers update
    // together from the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            k_r        <= '0;
            c_cnt      <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            error      <= 1'b0;
            core_start <= 1'b0;
            for (int i = 0; i < C_BEATS; i++) begin
                c_buf[i] <= '0;
            end
        end else begin
            case (state)
                ST_IDLE: begin
                    if (go) begin
                        done  <= 1'b0;
                        c_cnt <= '0;
                        if (cfg_ok) begin
                            k_r        <= cfg_k[AW-1:0];
                            error      <= 1'b0;
                            busy       <= 1'b1;
                            core_start <= 1'b1;
                            state      <= ST_SEND_A;
                        end else begin
                            // Illegal K: finish immediately, no streams.
                            error <= 1'b1;
                            state <= ST_FINISH;
                        end
                    end
                end

                ST_SEND_A: begin
                    if (a_last_hs) begin
                        state <= ST_SEND_B;
                    end
                end

                ST_SEND_B: begin
                    if (b_last_hs) begin
                        state <= ST_RECV_C;
                    end
                end

                ST_RECV_C: begin
                    if (c_hs) begin
                        c_buf[c_cnt] <= s_axis_c_tdata;
                        c_cnt        <= c_cnt + 2'd1;
                        if (c_cnt == C_LAST || s_axis_c_tlast) begin
                            busy       <= 1'b0;
                            core_start <= 1'b0;
                            state      <= ST_FINISH;
                            // Framing error: tlast early, or missing on beat 3.
                            if (s_axis_c_tlast != (c_cnt == C_LAST)) begin
                                error <= 1'b1;
                            end
                        end
                    end
                end

                ST_FINISH: begin
                    done  <= 1'b1;
                    state <= ST_IDLE;
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
